bnn_seq_layer: RTL and testbench
================================

// Module: bnn_seq_layer
// PURPOSE
//  Time-multiplexed binarized fully-connected layer: XNOR-popcount, per-neuron threshold and sign.
//  Parametrised successor to the fully-unrolled combinational BNN layers.
//  Processes CHUNK input bits per cycle; weights are read from an external 1-cycle-latency ROM.
//  Layers chain through valid/ready handshakes between the BNN stages.
// PARAMETERS
//  IN_BITS     288  input activation bits; must be a multiple of CHUNK
//  OUT_NEURONS 64   output neurons (output bits)
//  CHUNK       32   input bits processed per cycle (ROM word width)
//  THR_W       10   threshold width; must be >= ACC_W = $clog2(IN_BITS+1)
//  Derived:    NCH = IN_BITS/CHUNK, AW = $clog2(OUT_NEURONS*NCH)
// PORTS
//  clk_i        in   1                   clock, rising edge
//  rst_ni       in   1                   asynchronous active-low reset
//  in_valid_i   in   1                   input vector valid
//  in_ready_o   out  1                   block idle, accepting input
//  layer_i      in   IN_BITS             binarized input (1 = +1, 0 = -1)
//  w_addr_o     out  AW                  weight ROM word address = n*NCH + c
//  w_data_i     in   CHUNK               ROM data; returned 1 cycle after w_addr_o
//  thr_i        in   OUT_NEURONS*THR_W   per-neuron thresholds, static
//  sign_i       in   OUT_NEURONS*2       per-neuron mode, static
//  out_valid_o  out  1                   layer_o valid
//  out_ready_i  in   1                   consumer accepts layer_o
//  layer_o      out  OUT_NEURONS         binarized output, bit n = neuron n
// BEHAVIOUR
//  Reset values: in_ready_o=0 while rst_ni low, then 1 (IDLE); out_valid_o=0; layer_o=0; w_addr_o=0.
//  Counters, accumulator and read pipeline also clear on reset.
//  FSM:
//   IDLE->RUN on in_valid_i&&in_ready_o. layer_i is registered on that edge (E0).
//   RUN issues one address per cycle, c fastest then n, for OUT_NEURONS*NCH cycles (n,c never wrap).
//   RUN->DRAIN after the last address is issued; DRAIN lasts 1 cycle while the last word returns.
//   DRAIN->DONE: out_valid_o=1 exactly OUT_NEURONS*NCH+2 cycles after E0.
//   DONE->IDLE on out_valid_o&&out_ready_i. in_ready_o is high only in IDLE, so it returns the next cycle.
//  Datapath (read-return cycle):
//   pc  = popcount(~(in_chunk[c] ^ w_data_i)), ACC_W bits; in_chunk[c] = layer_i bits [c*CHUNK +: CHUNK].
//   acc = (c==0) ? pc : acc+pc.
//   On c==NCH-1, tot = acc+pc is compared unsigned against zero-extended thr[n]:
//    sign 2'b01: bit = (tot >= thr); 2'b10: bit = (tot < thr); 2'b00: bit = 0; 2'b11: bit = 1.
//   bit is written into out_reg[n].
//  Output: layer_o = out_reg, held stable while out_valid_o && !out_ready_i (backpressure has no limit).
//  Boundaries:
//   in_valid_i outside IDLE is ignored.
//   NCH==1: every read is a last chunk.
//   OUT_NEURONS*NCH==1: legal, latency 3.
//   rst_ni asserted mid RUN/DONE: returns to IDLE immediately; partial results are discarded; out_valid_o drops asynchronously.
//   thr > IN_BITS with sign 01 gives 0; thr==0 with sign 01 gives 1.
// CONFIGURATION
//  BNN_POPCNT_TAP_EN defined: adds outputs popcnt_o[ACC_W] and popcnt_valid_o.
//   On each neuron-finish cycle, popcnt_valid_o pulses 1 cycle with popcnt_o = tot.
//   Both are registered and appear 1 cycle after the compare; both reset to 0.
//  Undefined: these ports and their logic do not exist; all other behaviour is identical.
// TESTING (IN_BITS=64, CHUNK=32, OUT_NEURONS=4, THR_W=7)
//  1 Input all 0, ROM all 0 (pc=32 per chunk), thr=64, sign=01 for all neurons
//    -> layer_o=4'b1111, out_valid_o 10 cycles after E0; w_addr_o sequence 0..7.
//  2 Input all 1, ROM all 0 (tot=0); thr=1; sign n0..n3 = 01,10,00,11 -> layer_o=4'b1010.
//  3 Hold out_ready_i low 5 cycles after out_valid_o
//    -> layer_o stable, in_ready_o=0, w_addr_o static; IDLE the cycle after release.
//  4 Assert in_valid_i during RUN with different data -> ignored; result matches the first vector.
//  5 Pulse rst_ni low at cycle 4 of RUN -> out_valid_o=0 and in_ready_o=1 after release;
//    a new vector then yields the correct result.
//  6 BNN_POPCNT_TAP_EN, input/ROM giving tot = 64,0,32,17
//    -> 4 popcnt_valid_o pulses, 2 cycles apart, with popcnt_o = 64,0,32,17.

Source files
------------

// File: rtl/bnn_seq_layer.sv
// bnn_seq_layer: time-multiplexed binarized fully-connected layer.
// Each neuron's XNOR-popcount is accumulated CHUNK bits per cycle from a weight
// ROM with one cycle of read latency, then thresholded according to the neuron's
// two-bit sign mode.
// Optional feature macro: BNN_POPCNT_TAP_EN adds a registered per-neuron popcount tap.
module bnn_seq_layer #(
    parameter int IN_BITS     = 288,
    parameter int OUT_NEURONS = 64,
    parameter int CHUNK       = 32,
    parameter int THR_W       = 10,
    localparam int ACC_W      = $clog2(IN_BITS + 1),
    localparam int NCH        = IN_BITS / CHUNK,
    localparam int AW         = (OUT_NEURONS * NCH > 1) ? $clog2(OUT_NEURONS * NCH) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [IN_BITS-1:0]             layer_i,
    output logic [AW-1:0]                  w_addr_o,
    input  logic [CHUNK-1:0]               w_data_i,
    input  logic [OUT_NEURONS*THR_W-1:0]   thr_i,
    input  logic [OUT_NEURONS*2-1:0]       sign_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
`ifdef BNN_POPCNT_TAP_EN
    output logic [ACC_W-1:0]               popcnt_o,
    output logic                           popcnt_valid_o,
`endif
    output logic [OUT_NEURONS-1:0]         layer_o
);

    localparam int NW = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic                     valid_q, valid_d;
    logic [IN_BITS-1:0]       layer_q, layer_d;
    logic [NW-1:0]            n_q, n_d;
    logic [CW-1:0]            c_q, c_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic                     rd_vld_q, rd_vld_d;
    logic [NW-1:0]            rd_n_q, rd_n_d;
    logic [CW-1:0]            rd_c_q, rd_c_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [OUT_NEURONS-1:0]   out_q, out_d;
    logic [ACC_W-1:0]         pcnt_q, pcnt_d;
    logic                     pvld_q, pvld_d;

    logic [CHUNK-1:0]         chunk;
    logic [ACC_W-1:0]         pc;
    logic [ACC_W-1:0]         tot;
    logic [THR_W-1:0]         thr;
    logic [1:0]               mode;
    logic                     last_issue;

    // Control: state sequencing, address issue and the read-pipeline tags
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        n_d        = n_q;
        c_d        = c_q;
        addr_d     = addr_q;
        rd_vld_d   = 1'b0;
        rd_n_d     = rd_n_q;
        rd_c_d     = rd_c_q;
        last_issue = (n_q == NW'(OUT_NEURONS - 1)) && (c_q == CW'(NCH - 1));
        case (state_q)
            IDLE: begin
                if (in_valid_i && ready_q) begin
                    state_d = RUN;
                    layer_d = layer_i;
                    n_d     = '0;
                    c_d     = '0;
                    addr_d  = '0;
                end
            end
            RUN: begin
                rd_vld_d = 1'b1;
                rd_n_d   = n_q;
                rd_c_d   = c_q;
                if (last_issue) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                    if (c_q == CW'(NCH - 1)) begin
                        c_d = '0;
                        n_d = n_q + NW'(1);
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                if (valid_q && out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_q == DONE) && !(valid_q && out_ready_i);
    end

    // Datapath: XNOR-popcount of the returning ROM word, accumulate, threshold on the last chunk
    always_comb begin
        acc_d  = acc_q;
        out_d  = out_q;
        pcnt_d = pcnt_q;
        pvld_d = 1'b0;
        chunk  = layer_q[int'(rd_c_q)*CHUNK +: CHUNK];
        pc     = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pc = pc + ACC_W'(~(chunk[i] ^ w_data_i[i]));
        end
        tot  = (rd_c_q == '0) ? pc : acc_q + pc;
        thr  = thr_i[int'(rd_n_q)*THR_W +: THR_W];
        mode = sign_i[int'(rd_n_q)*2 +: 2];
        if (rd_vld_q) begin
            acc_d = tot;
            if (rd_c_q == CW'(NCH - 1)) begin
                case (mode)
                    2'b01:   out_d[rd_n_q] = (THR_W'(tot) >= thr);
                    2'b10:   out_d[rd_n_q] = (THR_W'(tot) < thr);
                    2'b00:   out_d[rd_n_q] = 1'b0;
                    default: out_d[rd_n_q] = 1'b1;
                endcase
                pcnt_d = tot;
                pvld_d = 1'b1;
            end
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            layer_q  <= '0;
            n_q      <= '0;
            c_q      <= '0;
            addr_q   <= '0;
            rd_vld_q <= 1'b0;
            rd_n_q   <= '0;
            rd_c_q   <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            pcnt_q   <= '0;
            pvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            layer_q  <= layer_d;
            n_q      <= n_d;
            c_q      <= c_d;
            addr_q   <= addr_d;
            rd_vld_q <= rd_vld_d;
            rd_n_q   <= rd_n_d;
            rd_c_q   <= rd_c_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            pcnt_q   <= pcnt_d;
            pvld_q   <= pvld_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = valid_q;
    assign w_addr_o    = addr_q;
    assign layer_o     = out_q;

`ifdef BNN_POPCNT_TAP_EN
    assign popcnt_o       = pcnt_q;
    assign popcnt_valid_o = pvld_q;
`else
    logic unused_tap;
    assign unused_tap = ^{pcnt_q, pvld_q};
`endif

endmodule

// File: tb/tb_bnn_seq_layer.sv
// tb_bnn_seq_layer: directed and random checks of bnn_seq_layer against a
// plain-arithmetic reference model (IN_BITS=64, CHUNK=32, OUT_NEURONS=4, THR_W=7).
module tb_bnn_seq_layer;

    logic         clock;
    logic         rstN;
    logic         inValid;
    logic         inReady;
    logic [63:0]  layerIn;
    logic [2:0]   wAddr;
    logic [31:0]  wData;
    logic [27:0]  thrVec;
    logic [7:0]   signVec;
    logic         outValid;
    logic         outReady;
    logic [3:0]   layerOut;
    logic [31:0]  rom [8];
    int           nChecks;
    int           nFails;
`ifdef BNN_POPCNT_TAP_EN
    logic [6:0]   popcnt;
    logic         popcntValid;
    int           pcVals[$];
    time          pcTimes[$];
`endif

    bnn_seq_layer #(
        .IN_BITS(64), .OUT_NEURONS(4), .CHUNK(32), .THR_W(7)
    ) dut (
        .clk_i(clock),
        .rst_ni(rstN),
        .in_valid_i(inValid),
        .in_ready_o(inReady),
        .layer_i(layerIn),
        .w_addr_o(wAddr),
        .w_data_i(wData),
        .thr_i(thrVec),
        .sign_i(signVec),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
`ifdef BNN_POPCNT_TAP_EN
        .popcnt_o(popcnt),
        .popcnt_valid_o(popcntValid),
`endif
        .layer_o(layerOut)
    );

    // Free-running clock, period 10
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Weight ROM with one cycle of read latency
    always @(posedge clock) begin
        wData <= rom[wAddr];
    end

`ifdef BNN_POPCNT_TAP_EN
    // Record every popcount tap pulse with its time
    always @(negedge clock) begin
        if (popcntValid) begin
            pcVals.push_back(int'(popcnt));
            pcTimes.push_back($time);
        end
    end
`endif

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Total XNOR matches of neuron n over the whole input vector
    function automatic int modelTot(input logic [63:0] vec, input int n);
        int tot;
        logic [31:0] x;
        tot = 0;
        for (int c = 0; c < 2; c++) begin
            x = ~(vec[c*32 +: 32] ^ rom[n*2 + c]);
            tot += $countones(x);
        end
        return tot;
    endfunction

    // Expected binarized output for the current ROM, thresholds and modes
    function automatic logic [3:0] modelLayer(input logic [63:0] vec);
        logic [3:0] r;
        int tot;
        int t;
        for (int n = 0; n < 4; n++) begin
            tot = modelTot(vec, n);
            t   = int'(thrVec[n*7 +: 7]);
            case (signVec[n*2 +: 2])
                2'b01:   r[n] = (tot >= t);
                2'b10:   r[n] = (tot < t);
                2'b00:   r[n] = 1'b0;
                default: r[n] = 1'b1;
            endcase
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Launch one vector, check address order, latency and result, then hold
    // back-pressure for 'stall' cycles; stall<0 leaves the block in DONE
    task automatic applyStimulus(input string tag, input logic [63:0] vec, input bit garbage, input int stall);
        logic [3:0]  expLayer;
        logic [23:0] addrSeq;
        logic [23:0] expSeq;
        int          lat;
        int          k;
        expLayer = modelLayer(vec);
        k = 0;
        while (!inReady && k < 50) begin
            @(negedge clock);
            k++;
        end
        checkOutput({tag, "_ready"}, 64'(inReady), 64'd1);
        layerIn = vec;
        inValid = 1'b1;
        @(posedge clock);
        #1;
        inValid = 1'b0;
        layerIn = ~vec;
        lat     = -1;
        addrSeq = '0;
        expSeq  = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i < 8) begin
                addrSeq[i*3 +: 3] = wAddr;
                expSeq[i*3 +: 3]  = 3'(i);
            end
            if (garbage && i == 2) begin
                inValid = 1'b1;
                layerIn = {$urandom, $urandom};
            end
            if (garbage && i == 4) inValid = 1'b0;
            if (outValid) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd10);
        checkOutput({tag, "_addrseq"}, 64'(addrSeq), 64'(expSeq));
        checkOutput({tag, "_layer"}, 64'(layerOut), 64'(expLayer));
        if (stall >= 0) begin
            for (int s = 0; s < stall; s++) begin
                @(negedge clock);
                checkOutput({tag, "_hold"}, 64'({outValid, inReady, wAddr, layerOut}),
                            64'({1'b1, 1'b0, 3'd7, expLayer}));
            end
            outReady = 1'b1;
            @(posedge clock);
            #1;
            outReady = 1'b0;
            @(negedge clock);
            checkOutput({tag, "_idle"}, 64'({inReady, outValid}), 64'({1'b1, 1'b0}));
        end
    endtask

    initial begin
        nChecks  = 0;
        nFails   = 0;
        rstN     = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        layerIn  = '0;
        thrVec   = {4{7'd64}};
        signVec  = {4{2'b01}};
        for (int i = 0; i < 8; i++) rom[i] = '0;

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("rst_in_ready", 64'(inReady), 64'd0);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_layer", 64'(layerOut), 64'd0);
        checkOutput("rst_addr", 64'(wAddr), 64'd0);
        rstN = 1'b1;
        @(negedge clock);
        checkOutput("rst_release_ready", 64'(inReady), 64'd1);

        // All-zero input and ROM: every neuron reaches 64 >= 64
        applyStimulus("t1", 64'd0, 1'b0, 0);
        checkOutput("t1_const", 64'(layerOut), 64'hF);

        // tot=0 against thr=1 under all four modes
        thrVec  = {4{7'd1}};
        signVec = {2'b11, 2'b00, 2'b10, 2'b01};
        applyStimulus("t2", {64{1'b1}}, 1'b0, 0);
        checkOutput("t2_const", 64'(layerOut), 64'hA);

        // Random weights, five cycles of back-pressure
        for (int i = 0; i < 8; i++) rom[i] = $urandom;
        thrVec  = {7'd30, 7'd33, 7'd28, 7'd35};
        signVec = {2'b01, 2'b10, 2'b01, 2'b10};
        applyStimulus("t3", {$urandom, $urandom}, 1'b0, 5);

        // Stray in_valid while busy is ignored
        applyStimulus("t4", {$urandom, $urandom}, 1'b1, 0);

        // Reset pulse part-way through RUN
        layerIn = {$urandom, $urandom};
        inValid = 1'b1;
        @(posedge clock);
        #1;
        inValid = 1'b0;
        repeat (4) @(negedge clock);
        rstN = 1'b0;
        #1;
        checkOutput("t5_in_reset", 64'({outValid, inReady, wAddr}), 64'd0);
        @(negedge clock);
        rstN = 1'b1;
        @(negedge clock);
        checkOutput("t5_after_reset", 64'({inReady, outValid}), 64'({1'b1, 1'b0}));
        applyStimulus("t5_new", {$urandom, $urandom}, 1'b0, 0);

        // Reset while holding a finished result drops out_valid at once
        applyStimulus("t5_done", {$urandom, $urandom}, 1'b0, -1);
        rstN = 1'b0;
        #1;
        checkOutput("t5_done_reset", 64'({outValid, layerOut}), 64'd0);
        @(negedge clock);
        rstN = 1'b1;

        // Threshold extremes: thr=0 always fires, thr>64 never does
        thrVec  = {7'd127, 7'd65, 7'd0, 7'd0};
        signVec = {4{2'b01}};
        applyStimulus("thr_edge", {$urandom, $urandom}, 1'b0, 0);
        checkOutput("thr_edge_const", 64'(layerOut), 64'h3);

        // Fully random configurations
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) rom[i] = $urandom;
            for (int n = 0; n < 4; n++) begin
                thrVec[n*7 +: 7]  = 7'($urandom_range(0, 70));
                signVec[n*2 +: 2] = 2'($urandom);
            end
            applyStimulus($sformatf("rand%0d", r), {$urandom, $urandom}, 1'b0, r % 3);
        end

`ifdef BNN_POPCNT_TAP_EN
        // Tap pulses carry the per-neuron totals 64, 0, 32, 17
        rom[0] = 32'h0;          rom[1] = 32'h0;
        rom[2] = 32'hFFFF_FFFF;  rom[3] = 32'hFFFF_FFFF;
        rom[4] = 32'h0;          rom[5] = 32'hFFFF_FFFF;
        rom[6] = 32'hFFFE_0000;  rom[7] = 32'hFFFF_FFFF;
        pcVals.delete();
        pcTimes.delete();
        applyStimulus("t6", 64'd0, 1'b0, 0);
        checkOutput("t6_pulses", 64'(pcVals.size()), 64'd4);
        for (int p = 0; p < 4 && p < pcVals.size(); p++) begin
            checkOutput($sformatf("t6_tot%0d", p), 64'(pcVals[p]), 64'(modelTot(64'd0, p)));
            if (p > 0) checkOutput($sformatf("t6_gap%0d", p), 64'(pcTimes[p] - pcTimes[p-1]), 64'd20);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
